riscv_decode_queue: RTL and testbench

RISCV_DECODE_QUEUE -- requirements
Module: riscv_decode_queue

---
 rtl/riscv_decode_pkg.sv | 10 +
 rtl/riscv_sync_fifo.sv | 46 ++++
 rtl/riscv_decode_queue.sv | 59 +++++
 tb/tb_riscv_decode_queue.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/riscv_decode_pkg.sv
// riscv_decode_pkg: NOP encoding and RV32 register/funct3 field positions shared by decode-queue logic
package riscv_decode_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int REG_W = 5;
  localparam int F3_W = 3;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB = 7;
  localparam int F3_LSB = 12;
endpackage

// File: rtl/riscv_sync_fifo.sv
// riscv_sync_fifo: W-bit x DEPTH sync FIFO; ports i_clk/i_rstn(sync, low)/i_flush, i_push/i_wdata, i_pop/o_rdata, o_count/o_full/o_empty
module riscv_sync_fifo #(
  parameter int W = 96,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [W-1:0]               i_wdata,
  input  logic                       i_pop,
  output logic [W-1:0]               o_rdata,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  assign o_full = count_q == CW'(DEPTH);
  assign o_empty = count_q == '0;
  assign o_count = count_q;
  assign o_rdata = mem_q[rptr_q];
  always_comb begin
    do_push = i_push && !o_full && !i_flush;
    do_pop = i_pop && !o_empty && !i_flush;
    wptr_d = i_flush ? '0 : wptr_q + AW'(do_push);
    rptr_d = i_flush ? '0 : rptr_q + AW'(do_pop);
    count_d = i_flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge i_clk) if (do_push) mem_q[wptr_q] <= i_wdata;
endmodule

// File: rtl/riscv_decode_queue.sv
// riscv_decode_queue: fetch->decode queue with optional empty bypass, NOP on empty, rs1/rs2/rd/funct3 extraction; F-side valid/ready in, D-side valid/ready out, o_count/o_full/o_empty status
module riscv_decode_queue
  import riscv_decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter int BYPASS = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_flush,
  input  logic                     i_validF,
  output logic                     o_readyF,
  input  logic [XLEN-1:0]          i_instrF,
  input  logic [XLEN-1:0]          i_PCF,
  input  logic [XLEN-1:0]          i_PCPlus4F,
  output logic                     o_validD,
  input  logic                     i_readyD,
  output logic [XLEN-1:0]          o_instrD,
  output logic [XLEN-1:0]          o_PCD,
  output logic [XLEN-1:0]          o_PCPlus4D,
  output logic [REG_W-1:0]         o_rs1_addrD,
  output logic [REG_W-1:0]         o_rs2_addrD,
  output logic [REG_W-1:0]         o_rd_addrD,
  output logic [F3_W-1:0]          o_funct3D,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam logic [XLEN-1:0] NOP_X = XLEN'(NOP);
  logic [3*XLEN-1:0] head;
  logic bypass, push, pop;
  assign o_readyF = !o_full && i_rstn && !i_flush;
  always_comb begin
    bypass = (BYPASS != 0) && o_empty && i_validF && o_readyF;
    o_validD = (BYPASS != 0 && i_flush) ? 1'b0 : (!o_empty || bypass);
    pop = o_validD && i_readyD && !o_empty;
    // an entry handed straight to decode in the same cycle never lands in storage
    push = i_validF && o_readyF && !(bypass && i_readyD);
    {o_instrD, o_PCD, o_PCPlus4D} = bypass ? {i_instrF, i_PCF, i_PCPlus4F} :
                                    o_empty ? {NOP_X, {XLEN{1'b0}}, {XLEN{1'b0}}} : head;
  end
  assign o_rs1_addrD = o_instrD[RS1_LSB +: REG_W];
  assign o_rs2_addrD = o_instrD[RS2_LSB +: REG_W];
  assign o_rd_addrD = o_instrD[RD_LSB +: REG_W];
  assign o_funct3D = o_instrD[F3_LSB +: F3_W];
  riscv_sync_fifo #(.W(3*XLEN), .DEPTH(DEPTH)) u_fifo (
    .i_clk(i_clk),
    .i_rstn(i_rstn),
    .i_flush(i_flush),
    .i_push(push),
    .i_wdata({i_instrF, i_PCF, i_PCPlus4F}),
    .i_pop(pop),
    .o_rdata(head),
    .o_count(o_count),
    .o_full(o_full),
    .o_empty(o_empty)
  );
endmodule

// File: tb/tb_riscv_decode_queue.sv
// tb_riscv_decode_queue: directed checks of a BYPASS=0 and a BYPASS=1 queue sharing one stimulus
module tb_riscv_decode_queue;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn, flush, validF, readyD;
  logic [31:0] instrF, pcF, pc4F;
  logic a_readyF, a_validD, a_full, a_empty;
  logic [31:0] a_instrD, a_pcD, a_pc4D;
  logic [4:0] a_rs1, a_rs2, a_rd;
  logic [2:0] a_f3, a_count;
  logic b_readyF, b_validD, b_full, b_empty;
  logic [31:0] b_instrD, b_pcD, b_pc4D;
  logic [4:0] b_rs1, b_rs2, b_rd;
  logic [2:0] b_f3, b_count;
  int errs = 0, checks = 0;
  riscv_decode_queue #(.XLEN(32), .DEPTH(4), .BYPASS(0)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_validF(validF), .o_readyF(a_readyF),
    .i_instrF(instrF), .i_PCF(pcF), .i_PCPlus4F(pc4F), .o_validD(a_validD), .i_readyD(readyD),
    .o_instrD(a_instrD), .o_PCD(a_pcD), .o_PCPlus4D(a_pc4D), .o_rs1_addrD(a_rs1),
    .o_rs2_addrD(a_rs2), .o_rd_addrD(a_rd), .o_funct3D(a_f3), .o_count(a_count),
    .o_full(a_full), .o_empty(a_empty)
  );
  riscv_decode_queue #(.XLEN(32), .DEPTH(4), .BYPASS(1)) dut_b (
    .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_validF(validF), .o_readyF(b_readyF),
    .i_instrF(instrF), .i_PCF(pcF), .i_PCPlus4F(pc4F), .o_validD(b_validD), .i_readyD(readyD),
    .o_instrD(b_instrD), .o_PCD(b_pcD), .o_PCPlus4D(b_pc4D), .o_rs1_addrD(b_rs1),
    .o_rs2_addrD(b_rs2), .o_rd_addrD(b_rd), .o_funct3D(b_f3), .o_count(b_count),
    .o_full(b_full), .o_empty(b_empty)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    validF = v;
    instrF = ins;
    pcF = pc;
    pc4F = pc + 32'd4;
  endtask
  initial begin
    rstn = 1'b0;
    flush = 1'b0;
    readyD = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    repeat (2) tick;
    check("rst count", a_count, 0);
    check("rst empty", a_empty, 1);
    check("rst full", a_full, 0);
    check("rst validD", a_validD, 0);
    check("rst readyF", a_readyF, 0);
    check("rst nop", a_instrD, 32'h13);
    check("rst pcD", a_pcD, 0);
    check("rst b validD", b_validD, 0);
    rstn = 1'b1;
    #1 check("post rst readyF", a_readyF, 1);
    readyD = 1'b1;
    drive(1'b1, 32'h00500093, 32'h0);
    #1 check("latency no valid", a_validD, 0);
    tick;
    check("e0 valid", a_validD, 1);
    check("e0 instr", a_instrD, 32'h00500093);
    check("e0 rd", a_rd, 1);
    check("e0 pc", a_pcD, 0);
    check("e0 pc4", a_pc4D, 4);
    drive(1'b1, 32'h00A00113, 32'h4);
    tick;
    check("e1 instr", a_instrD, 32'h00A00113);
    check("e1 rd", a_rd, 2);
    check("e1 pc", a_pcD, 4);
    check("e1 count", a_count, 1);
    drive(1'b0, 32'h0, 32'h0);
    tick;
    check("drain empty", a_empty, 1);
    check("drain validD", a_validD, 0);
    check("drain nop", a_instrD, 32'h13);
    check("drain rs1", a_rs1, 0);
    readyD = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h1000 + i, 32'h100 + 4 * i);
      tick;
    end
    check("full count", a_count, 4);
    check("full flag", a_full, 1);
    check("full readyF", a_readyF, 0);
    check("full head pc", a_pcD, 32'h100);
    check("full head instr", a_instrD, 32'h1000);
    readyD = 1'b1;
    #1 check("full pop readyF", a_readyF, 0);
    tick;
    check("pop from full count", a_count, 3);
    check("pop from full head", a_pcD, 32'h104);
    check("pop from full flag", a_full, 0);
    readyD = 1'b0;
    tick;
    check("refill count", a_count, 4);
    check("refill full", a_full, 1);
    flush = 1'b1;
    #1 check("flush readyF", a_readyF, 0);
    tick;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    check("flush count", a_count, 0);
    check("flush validD", a_validD, 0);
    check("flush nop", a_instrD, 32'h13);
    check("flush readyF after", a_readyF, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h2000 + i, 32'h200 + 4 * i);
      tick;
    end
    drive(1'b0, 32'h0, 32'h0);
    check("pre rst count", a_count, 3);
    rstn = 1'b0;
    tick;
    check("mid rst count", a_count, 0);
    check("mid rst empty", a_empty, 1);
    check("mid rst validD", a_validD, 0);
    check("mid rst readyF", a_readyF, 0);
    rstn = 1'b1;
    readyD = 1'b1;
    for (int k = 0; k < 13; k++) begin
      drive(1'b1, 32'h3000 + k, 4 * k);
      tick;
      check("stream pc", a_pcD, 4 * k);
      check("stream count", a_count, 1);
    end
    drive(1'b0, 32'h0, 32'h0);
    tick;
    check("stream drain", a_count, 0);
    drive(1'b1, 32'h002081B3, 32'h40);
    #1;
    check("byp validD", b_validD, 1);
    check("byp rs1", b_rs1, 1);
    check("byp rs2", b_rs2, 2);
    check("byp rd", b_rd, 3);
    check("byp pc", b_pcD, 32'h40);
    check("nobyp validD", a_validD, 0);
    tick;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    check("byp count", b_count, 0);
    check("byp after validD", b_validD, 0);
    readyD = 1'b0;
    drive(1'b1, 32'h00300193, 32'h44);
    #1 check("byp stall validD", b_validD, 1);
    tick;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    check("byp stored count", b_count, 1);
    check("byp stored instr", b_instrD, 32'h00300193);
    tick;
    check("byp stall hold", b_pcD, 32'h44);
    flush = 1'b1;
    drive(1'b1, 32'h00400213, 32'h48);
    #1 check("byp flush validD", b_validD, 0);
    tick;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    check("byp flush count", b_count, 0);
    check("byp flush nop", b_instrD, 32'h13);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
